// File: rtl/ex_stage_if.sv
// ----------------------------------------------------------------------------
// ex_stage_if: bundle between the ID/EX register and the execute stage, plus
// the execute-stage results that feed the EX/MEM register.
//
// Also holds the shared bus-width and opcode macros used by ex_stage.
//
// Modports:
//   slave  : the execute stage (takes ID/EX fields, drives results)
//   master : the upstream/downstream pipeline side (or a testbench)
//
// Signals:
//   aluop_i, alusel_i   operation and result class from ID/EX
//   reg1_i, reg2_i      operands (rs value, rt value or immediate)
//   wd_i, wreg_i        destination register address / write enable
//   hi_i, lo_i          current HI/LO, already forwarded
//   flush_i             annul the in-flight instruction
//   wd_o, wreg_o        destination address / write enable to EX/MEM
//   wdata_o             GPR write data
//   whilo_o, hi_o, lo_o HI/LO write enable and values
//   stallreq_o          hold IF..EX while the divider is busy
//   ovassert_o          signed-overflow flag (only when EX_OVF_TRAP_EN is defined)
//
// Optional feature macro: EX_OVF_TRAP_EN
// ----------------------------------------------------------------------------
`ifndef EX_DEFINES_SV
`define EX_DEFINES_SV
`define RegBus       31:0
`define RegAddrBus   4:0
`define AluOpBus     7:0
`define AluSelBus    2:0
`define WriteEnable  1'b1
`define WriteDisable 1'b0

`define EXE_NOP_OP   8'b00000000
`define EXE_AND_OP   8'b00100100
`define EXE_OR_OP    8'b00100101
`define EXE_XOR_OP   8'b00100110
`define EXE_NOR_OP   8'b00100111
`define EXE_SLL_OP   8'b01111100
`define EXE_SRL_OP   8'b00000010
`define EXE_SRA_OP   8'b00000011
`define EXE_MFHI_OP  8'b00010000
`define EXE_MTHI_OP  8'b00010001
`define EXE_MFLO_OP  8'b00010010
`define EXE_MTLO_OP  8'b00010011
`define EXE_SLT_OP   8'b00101010
`define EXE_SLTU_OP  8'b00101011
`define EXE_ADD_OP   8'b00100000
`define EXE_ADDU_OP  8'b00100001
`define EXE_SUB_OP   8'b00100010
`define EXE_SUBU_OP  8'b00100011
`define EXE_ADDI_OP  8'b01010101
`define EXE_DIV_OP   8'b00011010
`define EXE_DIVU_OP  8'b00011011

`define EXE_RES_NOP        3'b000
`define EXE_RES_LOGIC      3'b001
`define EXE_RES_SHIFT      3'b010
`define EXE_RES_MOVE       3'b011
`define EXE_RES_ARITHMETIC 3'b100
`endif

interface ex_stage_if;
    logic [`AluOpBus]   aluop_i;
    logic [`AluSelBus]  alusel_i;
    logic [`RegBus]     reg1_i;
    logic [`RegBus]     reg2_i;
    logic [`RegAddrBus] wd_i;
    logic               wreg_i;
    logic [`RegBus]     hi_i;
    logic [`RegBus]     lo_i;
    logic               flush_i;
    logic [`RegAddrBus] wd_o;
    logic               wreg_o;
    logic [`RegBus]     wdata_o;
    logic               whilo_o;
    logic [`RegBus]     hi_o;
    logic [`RegBus]     lo_o;
    logic               stallreq_o;
`ifdef EX_OVF_TRAP_EN
    logic               ovassert_o;
`endif

    // Handshake: there is no valid/ready pair. ID/EX presents one instruction
    // per cycle; when stallreq_o is high the upstream holds aluop_i/operands
    // stable and the instruction is consumed on the first edge where
    // stallreq_o is low. flush_i annuls whatever is present that cycle.
    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
`ifdef EX_OVF_TRAP_EN
        , output ovassert_o
`endif
    );

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
`ifdef EX_OVF_TRAP_EN
        , input ovassert_o
`endif
    );
endinterface

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage: execute stage of the 5-stage pipeline.
//
// Non-divide operations are purely combinational from the ID/EX fields.
// DIV/DIVU run on a radix-2 restoring divider (DIV_ITER iterations) and
// request a pipeline stall until the DONE cycle, in which HI/LO are written.
//
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous active-low reset (rst==0 resets)
//   bus  : ex_stage_if.slave (ID/EX inputs, EX/MEM outputs, stall request)
//
// Parameters:
//   DIV_ITER : divider iterations, must equal the register width (32)
//
// Optional feature macro: EX_OVF_TRAP_EN
//   Adds signed-overflow detection for ADD/SUB/ADDI; on overflow the GPR
//   write is suppressed and bus.ovassert_o is raised. Without it, ADD/SUB/ADDI
//   behave as ADDU/SUBU.
//
// Debug: div_state holds the divider FSM state for checkers.
// ----------------------------------------------------------------------------
module ex_stage #(
    parameter int DIV_ITER = 32
) (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam logic [DIV_ITER-1:0] CNT_LAST = DIV_ITER'(DIV_ITER - 1);
    localparam logic [DIV_ITER-1:0] CNT_ONE  = DIV_ITER'(1);

    div_state_t          div_state;
    div_state_t          div_state_nxt;
    logic [DIV_ITER-1:0] cnt;
    logic [`RegBus]      dvd;      // dividend, shifts out as quotient shifts in
    logic [`RegBus]      dvs;      // divisor magnitude
    logic [`RegBus]      rem;      // partial remainder
    logic                q_neg;
    logic                r_neg;

    logic                is_div;
    logic                is_sdiv;
    logic                div_zero;
    logic [`RegBus]      abs_a;
    logic [`RegBus]      abs_b;
    logic [32:0]         shifted;
    logic [32:0]         trial;

    logic [`RegBus]      logic_res;
    logic [`RegBus]      shift_res;
    logic [`RegBus]      arith_res;
    logic [`RegBus]      move_res;
    logic [`RegBus]      sum;
    logic [`RegBus]      diff;
    logic                ov;

    assign is_sdiv  = (bus.aluop_i == `EXE_DIV_OP);
    assign is_div   = is_sdiv || (bus.aluop_i == `EXE_DIVU_OP);
    assign div_zero = (bus.reg2_i == 32'd0);
    assign abs_a    = (is_sdiv && bus.reg1_i[31]) ? (32'd0 - bus.reg1_i) : bus.reg1_i;
    assign abs_b    = (is_sdiv && bus.reg2_i[31]) ? (32'd0 - bus.reg2_i) : bus.reg2_i;

    // One restoring step: bring the next dividend bit into the remainder and
    // keep the subtraction only if it did not borrow (trial[32]==0).
    assign shifted = {rem, dvd[31]};
    assign trial   = shifted - {1'b0, dvs};

    assign sum  = bus.reg1_i + bus.reg2_i;
    assign diff = bus.reg1_i - bus.reg2_i;

    // ------------------------------------------------------------------
    // Divider FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_state <= DIV_IDLE;
        end else begin
            div_state <= div_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Divider FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        div_state_nxt = div_state;
        if (bus.flush_i) begin
            div_state_nxt = DIV_IDLE;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (is_div) begin
                        div_state_nxt = div_zero ? DIV_DONE : DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (cnt == CNT_LAST) begin
                        div_state_nxt = DIV_DONE;
                    end
                end
                DIV_DONE: div_state_nxt = DIV_IDLE;
                default:  div_state_nxt = DIV_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Divider datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (!bus.flush_i && div_state == DIV_IDLE && is_div) begin
            cnt <= '0;
            if (div_zero) begin
                // Preload so DONE reads lo=all ones, hi=original dividend.
                dvd   <= 32'hFFFF_FFFF;
                rem   <= bus.reg1_i;
                dvs   <= '0;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
            end else begin
                dvd   <= abs_a;
                rem   <= '0;
                dvs   <= abs_b;
                q_neg <= is_sdiv && (bus.reg1_i[31] ^ bus.reg2_i[31]);
                r_neg <= is_sdiv && bus.reg1_i[31];
            end
        end else if (!bus.flush_i && div_state == DIV_BUSY) begin
            dvd <= {dvd[30:0], ~trial[32]};
            rem <= trial[32] ? shifted[31:0] : trial[31:0];
            cnt <= (cnt == CNT_LAST) ? '0 : (cnt + CNT_ONE);
        end
    end

    // ------------------------------------------------------------------
    // ALU result classes
    // ------------------------------------------------------------------
    always_comb begin
        logic_res = '0;
        case (bus.aluop_i)
            `EXE_AND_OP: logic_res = bus.reg1_i & bus.reg2_i;
            `EXE_OR_OP:  logic_res = bus.reg1_i | bus.reg2_i;
            `EXE_XOR_OP: logic_res = bus.reg1_i ^ bus.reg2_i;
            `EXE_NOR_OP: logic_res = ~(bus.reg1_i | bus.reg2_i);
            default:     logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (bus.aluop_i)
            `EXE_SLL_OP: shift_res = bus.reg2_i << bus.reg1_i[4:0];
            `EXE_SRL_OP: shift_res = bus.reg2_i >> bus.reg1_i[4:0];
            `EXE_SRA_OP: shift_res = $signed(bus.reg2_i) >>> bus.reg1_i[4:0];
            default:     shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (bus.aluop_i)
            `EXE_ADD_OP, `EXE_ADDU_OP, `EXE_ADDI_OP: arith_res = sum;
            `EXE_SUB_OP, `EXE_SUBU_OP:               arith_res = diff;
            `EXE_SLT_OP:  arith_res = {31'd0, ($signed(bus.reg1_i) < $signed(bus.reg2_i))};
            `EXE_SLTU_OP: arith_res = {31'd0, (bus.reg1_i < bus.reg2_i)};
            default:      arith_res = '0;
        endcase
    end

    always_comb begin
        move_res = '0;
        case (bus.aluop_i)
            `EXE_MFHI_OP: move_res = bus.hi_i;
            `EXE_MFLO_OP: move_res = bus.lo_i;
            default:      move_res = '0;
        endcase
    end

`ifdef EX_OVF_TRAP_EN
    // Signed overflow: operands of equal sign (add) or opposite sign (sub)
    // producing a result whose sign differs from operand 1.
    always_comb begin
        ov = 1'b0;
        case (bus.aluop_i)
            `EXE_ADD_OP, `EXE_ADDI_OP:
                ov = (bus.reg1_i[31] == bus.reg2_i[31]) && (sum[31] != bus.reg1_i[31]);
            `EXE_SUB_OP:
                ov = (bus.reg1_i[31] != bus.reg2_i[31]) && (diff[31] != bus.reg1_i[31]);
            default: ov = 1'b0;
        endcase
    end
`else
    assign ov = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output selection
    // ------------------------------------------------------------------
    always_comb begin
        bus.wd_o       = bus.wd_i;
        bus.wreg_o     = bus.wreg_i;
        bus.wdata_o    = '0;
        bus.whilo_o    = 1'b0;
        bus.hi_o       = '0;
        bus.lo_o       = '0;
        bus.stallreq_o = 1'b0;
`ifdef EX_OVF_TRAP_EN
        bus.ovassert_o = ov;
`endif

        case (bus.alusel_i)
            `EXE_RES_LOGIC:      bus.wdata_o = logic_res;
            `EXE_RES_SHIFT:      bus.wdata_o = shift_res;
            `EXE_RES_ARITHMETIC: bus.wdata_o = arith_res;
            `EXE_RES_MOVE:       bus.wdata_o = move_res;
            default:             bus.wdata_o = '0;
        endcase

        if (ov) begin
            bus.wreg_o = `WriteDisable;
        end

        if (bus.aluop_i == `EXE_MTHI_OP) begin
            bus.whilo_o = 1'b1;
            bus.hi_o    = bus.reg1_i;
            bus.lo_o    = bus.lo_i;
        end else if (bus.aluop_i == `EXE_MTLO_OP) begin
            bus.whilo_o = 1'b1;
            bus.hi_o    = bus.hi_i;
            bus.lo_o    = bus.reg1_i;
        end

        if (is_div) begin
            bus.wreg_o = `WriteDisable;
        end

        case (div_state)
            DIV_IDLE: bus.stallreq_o = is_div;
            DIV_BUSY: bus.stallreq_o = 1'b1;
            DIV_DONE: begin
                bus.wreg_o  = `WriteDisable;
                bus.whilo_o = 1'b1;
                bus.lo_o    = q_neg ? (32'd0 - dvd) : dvd;
                bus.hi_o    = r_neg ? (32'd0 - rem) : rem;
            end
            default: bus.stallreq_o = 1'b0;
        endcase

        if (bus.flush_i) begin
            bus.stallreq_o = 1'b0;
            bus.whilo_o    = 1'b0;
            bus.wreg_o     = `WriteDisable;
`ifdef EX_OVF_TRAP_EN
            bus.ovassert_o = 1'b0;
`endif
        end

        // Asynchronous reset also forces the combinational outputs low.
        if (!rst) begin
            bus.wd_o       = '0;
            bus.wreg_o     = `WriteDisable;
            bus.wdata_o    = '0;
            bus.whilo_o    = 1'b0;
            bus.hi_o       = '0;
            bus.lo_o       = '0;
            bus.stallreq_o = 1'b0;
`ifdef EX_OVF_TRAP_EN
            bus.ovassert_o = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage: self-checking bench for ex_stage.
// Expected result words are pushed to exp_q when stimulus is driven and
// popped when the DUT presents its result.
// Expected word layout: {wd, wreg, whilo, wdata, hi, lo}.
// ----------------------------------------------------------------------------
module tb_ex_stage;

    localparam logic [7:0] OP_NOP  = 8'b00000000;
    localparam logic [7:0] OP_AND  = 8'b00100100;
    localparam logic [7:0] OP_OR   = 8'b00100101;
    localparam logic [7:0] OP_XOR  = 8'b00100110;
    localparam logic [7:0] OP_NOR  = 8'b00100111;
    localparam logic [7:0] OP_SLL  = 8'b01111100;
    localparam logic [7:0] OP_SRL  = 8'b00000010;
    localparam logic [7:0] OP_SRA  = 8'b00000011;
    localparam logic [7:0] OP_MFHI = 8'b00010000;
    localparam logic [7:0] OP_MTHI = 8'b00010001;
    localparam logic [7:0] OP_MFLO = 8'b00010010;
    localparam logic [7:0] OP_MTLO = 8'b00010011;
    localparam logic [7:0] OP_SLT  = 8'b00101010;
    localparam logic [7:0] OP_SLTU = 8'b00101011;
    localparam logic [7:0] OP_ADD  = 8'b00100000;
    localparam logic [7:0] OP_ADDU = 8'b00100001;
    localparam logic [7:0] OP_SUB  = 8'b00100010;
    localparam logic [7:0] OP_SUBU = 8'b00100011;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;
    localparam logic [7:0] OP_BAD  = 8'b11111111;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    localparam int W = 103;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        wreg;
        logic        flush;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        x_wreg;
        logic        x_whilo;
        logic [31:0] x_wdata;
        logic [31:0] x_hi;
        logic [31:0] x_lo;
    } alu_vec_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;
    logic [W-1:0] obs_w;
    int           checks;
    int           failures;
    alu_vec_t     vecs[20];

    ex_stage_if bus ();

    ex_stage #(.DIV_ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.aluop_i  = OP_NOP;
        bus.alusel_i = SEL_NOP;
        bus.reg1_i   = 32'd0;
        bus.reg2_i   = 32'd0;
        bus.wd_i     = 5'd0;
        bus.wreg_i   = 1'b0;
        bus.hi_i     = 32'd0;
        bus.lo_i     = 32'd0;
        bus.flush_i  = 1'b0;
    endtask

    function automatic logic [W-1:0] observe();
        return {bus.wd_o, bus.wreg_o, bus.whilo_o, bus.wdata_o, bus.hi_o, bus.lo_o};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        bus.aluop_i  = OP_OR;
        bus.alusel_i = SEL_LOGIC;
        bus.reg1_i   = 32'h1234_5678;
        bus.wd_i     = 5'd9;
        bus.wreg_i   = 1'b1;
        #2;
        checks++;
        if (observe() !== '0 || bus.stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h stall=%b exp=0", observe(), bus.stallreq_o);
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (observe() !== '0 || bus.stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_nop got=%h stall=%b exp=0", observe(), bus.stallreq_o);
        end
    endtask

    task automatic test_alu();
        logic x_wreg_add;
`ifdef EX_OVF_TRAP_EN
        x_wreg_add = 1'b0;
`else
        x_wreg_add = 1'b1;
`endif
        vecs[0]  = '{OP_OR,   SEL_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0F0F_F0F0, 32'h0, 32'h0};
        vecs[1]  = '{OP_AND,  SEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0F00_0F00, 32'h0, 32'h0};
        vecs[2]  = '{OP_XOR,  SEL_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hF0F0_0F0F, 32'h0, 32'h0};
        vecs[3]  = '{OP_NOR,  SEL_LOGIC, 32'h0000_0000, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 32'h0};
        vecs[4]  = '{OP_SLL,  SEL_SHIFT, 32'h0000_0024, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0};
        vecs[5]  = '{OP_SRL,  SEL_SHIFT, 32'h0000_001F, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 32'h0, 32'h0};
        vecs[6]  = '{OP_SRA,  SEL_SHIFT, 32'h0000_0004, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hF800_0000, 32'h0, 32'h0};
        vecs[7]  = '{OP_SRA,  SEL_SHIFT, 32'h0000_0004, 32'h4000_0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0400_0000, 32'h0, 32'h0};
        vecs[8]  = '{OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 32'h0, 32'h0};
        vecs[9]  = '{OP_SUBU, SEL_ARITH, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        vecs[10] = '{OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 32'h0, 32'h0};
        vecs[11] = '{OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0};
        vecs[12] = '{OP_MFHI, SEL_MOVE,  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 32'h0};
        vecs[13] = '{OP_MFLO, SEL_MOVE,  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'h9ABC_DEF0, 32'h0, 32'h0};
        vecs[14] = '{OP_MTHI, SEL_NOP,   32'hAAAA_5555, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'h0, 32'hAAAA_5555, 32'h0000_0002};
        vecs[15] = '{OP_MTLO, SEL_NOP,   32'h5555_AAAA, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'h0, 32'h0000_0001, 32'h5555_AAAA};
        vecs[16] = '{OP_NOP,  SEL_NOP,   32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[17] = '{OP_BAD,  SEL_LOGIC, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[18] = '{OP_OR,   SEL_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0F0F_F0F0, 32'h0, 32'h0};
        vecs[19] = '{OP_ADD,  SEL_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 32'h0, x_wreg_add, 1'b0, 32'h8000_0000, 32'h0, 32'h0};

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.aluop_i  = vecs[i].op;
            bus.alusel_i = vecs[i].sel;
            bus.reg1_i   = vecs[i].a;
            bus.reg2_i   = vecs[i].b;
            bus.wd_i     = 5'(i + 1);
            bus.wreg_i   = vecs[i].wreg;
            bus.hi_i     = vecs[i].hi;
            bus.lo_i     = vecs[i].lo;
            bus.flush_i  = vecs[i].flush;
            exp_q.push_back({5'(i + 1), vecs[i].x_wreg, vecs[i].x_whilo,
                             vecs[i].x_wdata, vecs[i].x_hi, vecs[i].x_lo});
            @(negedge clk);
            obs_w = observe();
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_w !== exp_w || bus.stallreq_o !== 1'b0) begin
                failures++;
                $display("FAIL alu[%0d] got=%h stall=%b exp=%h stall=0", i, obs_w, bus.stallreq_o, exp_w);
            end
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic test_ovf();
        logic [7:0]  ops[3];
        logic [31:0] as[3];
        logic [31:0] bs[3];
        logic [31:0] sums[3];
        logic        ovs[3];
        ops[0] = OP_ADD; as[0] = 32'h7FFF_FFFF; bs[0] = 32'h0000_0001; sums[0] = 32'h8000_0000; ovs[0] = 1'b1;
        ops[1] = OP_ADD; as[1] = 32'h0000_0001; bs[1] = 32'h0000_0001; sums[1] = 32'h0000_0002; ovs[1] = 1'b0;
        ops[2] = OP_SUB; as[2] = 32'h8000_0000; bs[2] = 32'h0000_0001; sums[2] = 32'h7FFF_FFFF; ovs[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic x_wreg;
`ifdef EX_OVF_TRAP_EN
            x_wreg = ~ovs[i];
`else
            x_wreg = 1'b1;
`endif
            @(posedge clk);
            #1;
            drive_idle();
            bus.aluop_i  = ops[i];
            bus.alusel_i = SEL_ARITH;
            bus.reg1_i   = as[i];
            bus.reg2_i   = bs[i];
            bus.wd_i     = 5'd7;
            bus.wreg_i   = 1'b1;
            exp_q.push_back({5'd7, x_wreg, 1'b0, sums[i], 32'h0, 32'h0});
            @(negedge clk);
            obs_w = observe();
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_w !== exp_w) begin
                failures++;
                $display("FAIL ovf[%0d] got=%h exp=%h", i, obs_w, exp_w);
            end
`ifdef EX_OVF_TRAP_EN
            checks++;
            if (bus.ovassert_o !== ovs[i]) begin
                failures++;
                $display("FAIL ovassert[%0d] got=%b exp=%b", i, bus.ovassert_o, ovs[i]);
            end
`endif
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // Issue one divide held under stall; compare the DONE cycle and stall length.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] x_lo, input logic [31:0] x_hi, input int x_stall);
        int   stalls;
        logic done;
        logic side_bad;
        stalls   = 0;
        done     = 1'b0;
        side_bad = 1'b0;
        @(posedge clk);
        #1;
        drive_idle();
        bus.aluop_i = op;
        bus.reg1_i  = a;
        bus.reg2_i  = b;
        bus.wd_i    = 5'd3;
        bus.wreg_i  = 1'b1;
        exp_q.push_back({5'd3, 1'b0, 1'b1, 32'h0, x_hi, x_lo});
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.stallreq_o === 1'b1) begin
                stalls++;
                if (bus.whilo_o !== 1'b0 || bus.wreg_o !== 1'b0) side_bad = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        exp_w = exp_q.pop_front();
        obs_w = observe();
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL div_timeout op=%h a=%h b=%h stalls=%0d", op, a, b, stalls);
        end else if (obs_w !== exp_w) begin
            failures++;
            $display("FAIL div_result op=%h a=%h b=%h got=%h exp=%h", op, a, b, obs_w, exp_w);
        end
        checks++;
        if (stalls != x_stall) begin
            failures++;
            $display("FAIL div_stall_len op=%h got=%0d exp=%0d", op, stalls, x_stall);
        end
        checks++;
        if (side_bad) begin
            failures++;
            $display("FAIL div_busy_writes op=%h got=1 exp=0", op);
        end
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if (bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL div_after_done whilo=%b stall=%b exp=0/0", bus.whilo_o, bus.stallreq_o);
        end
    endtask

    task automatic test_divide();
        logic [31:0] a;
        logic [31:0] b;
        run_div(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        run_div(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 65535));
            run_div(OP_DIVU, a, b, a / b, a % b, 33);
        end
    endtask

    task automatic test_flush();
        int   stalls;
        logic saw_whilo;
        stalls    = 0;
        saw_whilo = 1'b0;
        @(posedge clk);
        #1;
        drive_idle();
        bus.aluop_i = OP_DIVU;
        bus.reg1_i  = 32'd100;
        bus.reg2_i  = 32'd7;
        for (int c = 0; c < 50 && stalls < 11; c++) begin
            @(negedge clk);
            if (bus.stallreq_o === 1'b1) stalls++;
        end
        checks++;
        if (stalls != 11) begin
            failures++;
            $display("FAIL flush_setup stalls got=%0d exp=11", stalls);
        end
        @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        #1;
        checks++;
        if (bus.stallreq_o !== 1'b0 || bus.whilo_o !== 1'b0 || bus.wreg_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle stall=%b whilo=%b wreg=%b exp=0/0/0",
                     bus.stallreq_o, bus.whilo_o, bus.wreg_o);
        end
        @(posedge clk);
        #1;
        drive_idle();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) saw_whilo = 1'b1;
        end
        checks++;
        if (saw_whilo) begin
            failures++;
            $display("FAIL flush_aborted got=activity exp=idle");
        end
        run_div(OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33);
    endtask

    task automatic test_reset_mid_div();
        logic saw;
        saw = 1'b0;
        @(posedge clk);
        #1;
        drive_idle();
        bus.aluop_i = OP_DIVU;
        bus.reg1_i  = 32'd1000;
        bus.reg2_i  = 32'd3;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (observe() !== '0 || bus.stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got=%h stall=%b exp=0", observe(), bus.stallreq_o);
        end
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (observe() !== '0 || bus.stallreq_o !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL reset_discard got=activity exp=idle");
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu();
        test_ovf();
        test_divide();
        test_flush();
        test_reset_mid_div();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; sits directly downstream of the ID/EX register and consumes its ex_* outputs.
- Computes the ALU result and HI/LO write-back for the EX/MEM register.
- Contains a 32-iteration radix-2 restoring divider for DIV/DIVU.
- Raises a stall request while the divider is busy.

Parameters:
- DIV_ITER, 32, number of divider iterations; must equal the `RegBus width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-low reset (rst==0 resets).
- aluop_i  in  `AluOpBus  operation from ID/EX (ex_aluop).
- alusel_i  in  `AluSelBus  result class from ID/EX (ex_alusel).
- reg1_i  in  `RegBus  operand 1 (rs value).
- reg2_i  in  `RegBus  operand 2 (rt value or immediate).
- wd_i  in  `RegAddrBus  destination register address.
- wreg_i  in  1  destination write enable.
- hi_i  in  `RegBus  current HI, already forwarded.
- lo_i  in  `RegBus  current LO, already forwarded.
- flush_i  in  1  annul the in-flight instruction; aborts the divider.
- wd_o  out  `RegAddrBus  destination address to EX/MEM.
- wreg_o  out  1  write enable to EX/MEM.
- wdata_o  out  `RegBus  GPR write data.
- whilo_o  out  1  HI/LO write enable.
- hi_o  out  `RegBus  HI write value.
- lo_o  out  `RegBus  LO write value.
- stallreq_o  out  1  hold IF..EX; the ID/EX register keeps its contents while high.

Behaviour:
- Reset (rst==0, asynchronous):
  - Divider state goes to IDLE; counter, dividend/divisor/partial-remainder registers and sign flags clear to 0.
  - Outputs are 0, wreg_o=`WriteDisable, whilo_o=0, stallreq_o=0.
  - Reset mid-division discards the division with no HI/LO write.
- Non-divide ops are combinational from the current inputs (0-cycle latency); wd_o=wd_i.
- Logic ops (`EXE_RES_LOGIC): AND, OR, XOR, NOR.
- Shift ops (`EXE_RES_SHIFT): SLL, SRL, SRA.
  - Shift amount is reg1_i[4:0]; the shifted value is reg2_i.
  - SRA replicates reg2_i[31].
- Arithmetic ops (`EXE_RES_ARITHMETIC):
  - ADDU, SUBU wrap modulo 2^32.
  - SLT is a signed compare; SLTU is unsigned; result is 32'd1 or 32'd0.
- Move ops (`EXE_RES_MOVE): MFHI gives wdata_o=hi_i; MFLO gives wdata_o=lo_i.
- MTHI: whilo_o=1, hi_o=reg1_i, lo_o=lo_i.
- MTLO: whilo_o=1, lo_o=reg1_i, hi_o=hi_i.
- Unknown aluop or `EXE_NOP_OP gives wdata_o=0 and whilo_o=0.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE: when aluop_i is DIV/DIVU and flush_i=0, latch operands.
    - DIV latches absolute values and records the quotient sign (a^b) and remainder sign (a).
    - Clear the counter, assert stallreq_o, go to BUSY.
    - Divisor==0 skips BUSY and goes straight to DONE.
  - BUSY: one iteration per cycle (shift the remainder, trial-subtract, set the quotient bit); stallreq_o=1.
    - After DIV_ITER iterations go to DONE.
  - DONE: stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder, wreg_o=0; next state IDLE.
    - DIV negates the quotient/remainder according to the recorded signs.
- Latency:
  - Normal divide is DIV_ITER+2 cycles from first presentation to the DONE cycle; stall is held for DIV_ITER+1 cycles.
  - Divide by zero takes 2 cycles: lo_o=32'hFFFF_FFFF, hi_o=dividend (signed original for DIV).
- Divides never write a GPR; wreg_o=0 during all divide cycles.
- The result is delivered in the DONE cycle, while ID/EX still holds the DIV.
  - The pipeline advances at the next edge, so IDLE never re-triggers on the same instruction.
- flush_i=1 in any state: next state IDLE, stallreq_o=0 combinationally in that cycle, whilo_o=0, wreg_o=0.
- The DIV_ITER-bit counter wraps to 0 on entry to DONE.

Optional Feature:
- EX_OVF_TRAP_EN defined:
  - Adds signed ADD/SUB/ADDI handling and an output ovassert_o (1 bit).
  - On signed overflow: ovassert_o=1 and wreg_o=`WriteDisable (no GPR write).
  - Otherwise ovassert_o=0 and the op behaves as ADDU/SUBU.
- EX_OVF_TRAP_EN undefined: port ovassert_o is absent, and ADD/SUB decode as ADDU/SUBU.

Test Plan:
- Reset: rst=0 asynchronously mid-cycle -> all outputs 0 and stallreq_o=0 immediately; after release with NOP input, outputs stay 0.
- ALU: OR 32'h0000_F0F0 | 32'h0F0F_0000 -> wdata_o=32'h0F0F_F0F0 in the same cycle; SRA reg1=4, reg2=32'h8000_0000 -> 32'hF800_0000; SLT -1 vs 1 -> 1, SLTU -> 0.
- DIVU 100/7 held under stall -> stallreq_o high for exactly 33 cycles, then one DONE cycle with lo_o=14, hi_o=2, whilo_o=1, stallreq_o=0.
- DIV -7/2 -> lo_o=32'hFFFF_FFFD, hi_o=32'hFFFF_FFFF; DIVU 5/0 -> stall 1 cycle, then lo_o=32'hFFFF_FFFF, hi_o=5.
- flush_i pulse on BUSY iteration 10 -> stallreq_o=0 that cycle, no whilo_o; a following DIVU 9/3 completes normally with lo_o=3, hi_o=0.
- EX_OVF_TRAP_EN: ADD 32'h7FFF_FFFF+1 -> ovassert_o=1, wreg_o=0; with the macro undefined -> wdata_o=32'h8000_0000, wreg_o=1.
